// File: rtl/hazard_ctrl_mc.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_mc
// Hazard unit for a 5-stage pipeline that can also hold a multicycle
// instruction in E. It forwards GPR and CSR operands, detects load-use
// hazards, resolves taken branches, and freezes F/D/E while a multicycle
// instruction is still working.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   Rs1D, Rs2D, UsesRs1D/2D    D-stage sources and whether they are read
//   Rs1E, Rs2E, RdE            E-stage sources and destination
//   RdM, RdWB, RegWriteM/WB    later-stage destinations and write enables
//   ResultSrcE                 E-stage result select (load detection)
//   PCSrcE                     branch/jump taken in E
//   McE                        E instruction is multicycle (level)
//   CSRReadE, CSRAddrE/M/WB    CSR read in E and per-stage CSR addresses
//   CSRWriteM/WB               M / WB write a CSR
//   StallF/D/E, FlushD/E/M     pipeline register controls
//   ForwardAE/BE, ForwardCSRE  operand selects: 00 file, 01 WB, 10 M
//   McBusy                     multicycle stall active this cycle
//   McDoneE                    final E cycle of a multicycle instruction
//
// The controls are combinational: a multicycle stall has to take effect in
// the very cycle the instruction arrives in E, so they cannot be registered.
// ---------------------------------------------------------------------------
module hazard_ctrl_mc #(
    parameter int              MC_LATENCY = 4,
    parameter int              RS_W       = 3,
    parameter logic [RS_W-1:0] LOAD_SRC   = 3'b001
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic            UsesRs1D,
    input  logic            UsesRs2D,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdE,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdWB,
    input  logic            RegWriteM,
    input  logic            RegWriteWB,
    input  logic [RS_W-1:0] ResultSrcE,
    input  logic            PCSrcE,
    input  logic            McE,
    input  logic            CSRReadE,
    input  logic [11:0]     CSRAddrE,
    input  logic [11:0]     CSRAddrM,
    input  logic [11:0]     CSRAddrWB,
    input  logic            CSRWriteM,
    input  logic            CSRWriteWB,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushM,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic [1:0]      ForwardCSRE,
    output logic            McBusy,
    output logic            McDoneE
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MC_LAT_C = 4'(MC_LATENCY);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc_s;
    logic       mcstall_s;
    logic       mc_done_s;
    logic       pc_src_eff_s;
    logic       lw_s;

    // GPR forward select: M beats WB, x0 never forwards.
    function automatic logic [1:0] gpr_fwd(input logic [4:0] rs,
                                           input logic [4:0] rd_m,
                                           input logic       we_m,
                                           input logic [4:0] rd_wb,
                                           input logic       we_wb);
        logic [1:0] sel;
        if (we_m && (rs == rd_m) && (rs != 5'd0)) begin
            sel = 2'b10;
        end else if (we_wb && (rs == rd_wb) && (rs != 5'd0)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // CSR forward select: M beats WB, only when E actually reads a CSR.
    function automatic logic [1:0] csr_fwd(input logic        rd_e,
                                           input logic [11:0] addr_e,
                                           input logic [11:0] addr_m,
                                           input logic        we_m,
                                           input logic [11:0] addr_wb,
                                           input logic        we_wb);
        logic [1:0] sel;
        if (rd_e && we_m && (addr_m == addr_e)) begin
            sel = 2'b10;
        end else if (rd_e && we_wb && (addr_wb == addr_e)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign cnt_inc_s = cnt_q + 4'd1;

    // Multicycle FSM next state: cnt counts E cycles already spent.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcstall_s = 1'b0;
        mc_done_s = 1'b0;
        if (reset) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (McE) begin
                        if (MC_LATENCY > 1) begin
                            mcstall_s = 1'b1;
                            state_d   = BUSY;
                            cnt_d     = 4'd1;
                        end else begin
                            // Single-cycle "multicycle" op finishes at once.
                            mc_done_s = 1'b1;
                            state_d   = IDLE;
                            cnt_d     = 4'd0;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                BUSY: begin
                    // McE is ignored here: the held instruction owns E.
                    if (cnt_inc_s == MC_LAT_C) begin
                        mc_done_s = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = 4'd0;
                    end else begin
                        mcstall_s = 1'b1;
                        state_d   = BUSY;
                        cnt_d     = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Taken-branch qualifier and load-use detection; a branch seen while the
    // FSM is BUSY belongs to no real instruction and is dropped.
    always_comb begin
        if (state_q == IDLE) begin
            pc_src_eff_s = PCSrcE;
        end else begin
            pc_src_eff_s = 1'b0;
        end
        lw_s = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
               ((UsesRs1D && (Rs1D == RdE)) || (UsesRs2D && (Rs2D == RdE))) &&
               !pc_src_eff_s;
    end

    // Pipeline controls and forwarding selects.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        ForwardCSRE = 2'b00;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE   = gpr_fwd(Rs1E, RdM, RegWriteM, RdWB, RegWriteWB);
            ForwardBE   = gpr_fwd(Rs2E, RdM, RegWriteM, RdWB, RegWriteWB);
            ForwardCSRE = csr_fwd(CSRReadE, CSRAddrE, CSRAddrM, CSRWriteM,
                                  CSRAddrWB, CSRWriteWB);
            if (mcstall_s) begin
                // Freeze F/D/E and bubble M; load-use is moot while frozen,
                // which also keeps FlushE and StallE mutually exclusive.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallF = lw_s;
                StallD = lw_s;
                FlushD = pc_src_eff_s;
                FlushE = pc_src_eff_s | lw_s;
            end
        end
        McBusy  = mcstall_s;
        McDoneE = mc_done_s;
    end

    // FSM state and cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    localparam int         MC_LAT   = 4;
    localparam logic [2:0] LOAD_ENC = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdWB;
    logic        UsesRs1D, UsesRs2D, RegWriteM, RegWriteWB;
    logic [2:0]  ResultSrcE;
    logic        PCSrcE, McE, CSRReadE, CSRWriteM, CSRWriteWB;
    logic [11:0] CSRAddrE, CSRAddrM, CSRAddrWB;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]  ForwardAE, ForwardBE, ForwardCSRE;
    logic        McBusy, McDoneE;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles the current multicycle op still needs in E.
    int rem = 0;

    // Snapshot of DUT outputs from the last evaluated cycle.
    logic s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m;
    logic s_busy, s_done;
    logic [1:0] s_fa, s_fb, s_fc;

    hazard_ctrl_mc #(.MC_LATENCY(MC_LAT), .RS_W(3), .LOAD_SRC(LOAD_ENC)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdWB(RdWB),
        .RegWriteM(RegWriteM), .RegWriteWB(RegWriteWB),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McE(McE),
        .CSRReadE(CSRReadE), .CSRAddrE(CSRAddrE), .CSRAddrM(CSRAddrM),
        .CSRAddrWB(CSRAddrWB), .CSRWriteM(CSRWriteM), .CSRWriteWB(CSRWriteWB),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCSRE(ForwardCSRE),
        .McBusy(McBusy), .McDoneE(McDoneE)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [11:0] act,
                           input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs != 5'd0 && RegWriteM && rs == RdM) return 2'b10;
        if (rs != 5'd0 && RegWriteWB && rs == RdWB) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr_inputs();
        reset = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0; UsesRs1D = 1'b0; UsesRs2D = 1'b0;
        Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdWB = 5'd0;
        RegWriteM = 1'b0; RegWriteWB = 1'b0; ResultSrcE = 3'b000;
        PCSrcE = 1'b0; McE = 1'b0; CSRReadE = 1'b0; CSRWriteM = 1'b0;
        CSRWriteWB = 1'b0; CSRAddrE = 12'h000; CSRAddrM = 12'h000;
        CSRAddrWB = 12'h000;
    endtask

    // Inputs are already applied (at a negedge); evaluate, compare, advance.
    task automatic run_cycle();
        logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_busy, e_done, pcs, lw, occ;
        logic [1:0] e_fa, e_fb, e_fc;
        int r, rem_next;
        #1;
        s_stall_f = StallF; s_stall_d = StallD; s_stall_e = StallE;
        s_flush_d = FlushD; s_flush_e = FlushE; s_flush_m = FlushM;
        s_busy = McBusy; s_done = McDoneE;
        s_fa = ForwardAE; s_fb = ForwardBE; s_fc = ForwardCSRE;
        if (reset) begin
            {e_sf, e_sd, e_se} = 3'b000;
            {e_fd, e_fe, e_fm} = 3'b111;
            e_fa = 2'b00; e_fb = 2'b00; e_fc = 2'b00;
            e_busy = 1'b0; e_done = 1'b0; rem_next = 0;
        end else begin
            occ = 1'b1;
            if (rem > 0) r = rem;
            else if (McE) r = MC_LAT;
            else begin occ = 1'b0; r = 0; end
            e_busy = occ && (r > 1);
            e_done = occ && (r == 1);
            rem_next = occ ? r - 1 : 0;
            pcs = PCSrcE && (rem == 0);
            lw = (ResultSrcE == LOAD_ENC) && (RdE != 5'd0) &&
                 ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE)) && !pcs;
            if (e_busy) begin
                {e_sf, e_sd, e_se} = 3'b111;
                {e_fd, e_fe, e_fm} = 3'b001;
            end else begin
                e_sf = lw; e_sd = lw; e_se = 1'b0;
                e_fd = pcs; e_fe = pcs | lw; e_fm = 1'b0;
            end
            e_fa = ref_fwd(Rs1E);
            e_fb = ref_fwd(Rs2E);
            if (CSRReadE && CSRWriteM && CSRAddrM == CSRAddrE) e_fc = 2'b10;
            else if (CSRReadE && CSRWriteWB && CSRAddrWB == CSRAddrE) e_fc = 2'b01;
            else e_fc = 2'b00;
        end
        chk_val("StallF", 12'(s_stall_f), 12'(e_sf));
        chk_val("StallD", 12'(s_stall_d), 12'(e_sd));
        chk_val("StallE", 12'(s_stall_e), 12'(e_se));
        chk_val("FlushD", 12'(s_flush_d), 12'(e_fd));
        chk_val("FlushE", 12'(s_flush_e), 12'(e_fe));
        chk_val("FlushM", 12'(s_flush_m), 12'(e_fm));
        chk_val("ForwardAE", 12'(s_fa), 12'(e_fa));
        chk_val("ForwardBE", 12'(s_fb), 12'(e_fb));
        chk_val("ForwardCSRE", 12'(s_fc), 12'(e_fc));
        chk_val("McBusy", 12'(s_busy), 12'(e_busy));
        chk_val("McDoneE", 12'(s_done), 12'(e_done));
        chk_val("StallE_FlushE_excl", 12'(s_stall_e & s_flush_e), 12'd0);
        rem = rem_next;
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] csr_pool [3];
        logic [3:0]  exp_busy;
        csr_pool[0] = 12'h300; csr_pool[1] = 12'h305; csr_pool[2] = 12'h341;
        clr_inputs();
        reset = 1'b1;
        @(negedge clk);

        // Reset values
        run_cycle();
        chk_val("rst_flushD", 12'(s_flush_d), 12'd1);
        chk_val("rst_busy", 12'(s_busy), 12'd0);
        run_cycle();
        reset = 1'b0;

        // GPR forwarding, M priority and x0
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdWB = 5'd5; RegWriteWB = 1'b1;
        run_cycle();
        chk_val("fwdA_m", 12'(s_fa), 12'h2);
        Rs1E = 5'd0;
        run_cycle();
        chk_val("fwdA_x0", 12'(s_fa), 12'h0);
        clr_inputs();

        // Load-use, then load-use killed by a taken branch
        ResultSrcE = LOAD_ENC; RdE = 5'd7; Rs2D = 5'd7; UsesRs2D = 1'b1;
        run_cycle();
        chk_val("lu_stallF", 12'(s_stall_f), 12'd1);
        chk_val("lu_stallD", 12'(s_stall_d), 12'd1);
        chk_val("lu_flushE", 12'(s_flush_e), 12'd1);
        PCSrcE = 1'b1;
        run_cycle();
        chk_val("br_stallF", 12'(s_stall_f), 12'd0);
        chk_val("br_flushD", 12'(s_flush_d), 12'd1);
        chk_val("br_flushE", 12'(s_flush_e), 12'd1);
        clr_inputs();
        run_cycle();

        // Two back-to-back multicycle ops; load-use during the stall cycles
        exp_busy = 4'b0111;
        McE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5 || i == 6) begin
                ResultSrcE = LOAD_ENC; RdE = 5'd7; Rs1D = 5'd7; UsesRs1D = 1'b1;
            end else begin
                ResultSrcE = 3'b000; UsesRs1D = 1'b0;
            end
            run_cycle();
            chk_val("mc_busy", 12'(s_busy), 12'(exp_busy[i % 4]));
            chk_val("mc_stallE", 12'(s_stall_e), 12'(exp_busy[i % 4]));
            chk_val("mc_flushM", 12'(s_flush_m), 12'(exp_busy[i % 4]));
            chk_val("mc_done", 12'(s_done), 12'((i % 4) == 3));
            chk_val("mc_flushE", 12'(s_flush_e), 12'd0);
        end
        clr_inputs();
        run_cycle();

        // Reset in the middle of a multicycle op, then a fresh full sequence
        McE = 1'b1;
        run_cycle();
        reset = 1'b1;
        run_cycle();
        chk_val("mrst_busy", 12'(s_busy), 12'd0);
        chk_val("mrst_flushE", 12'(s_flush_e), 12'd1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            chk_val("post_rst_busy", 12'(s_busy), 12'(i < 3));
            chk_val("post_rst_done", 12'(s_done), 12'(i == 3));
        end
        clr_inputs();
        run_cycle();

        // CSR forwarding
        CSRReadE = 1'b1; CSRAddrE = 12'h300; CSRWriteM = 1'b1; CSRAddrM = 12'h300;
        run_cycle();
        chk_val("csr_m", 12'(s_fc), 12'h2);
        CSRAddrM = 12'h305; CSRWriteWB = 1'b1; CSRAddrWB = 12'h300;
        run_cycle();
        chk_val("csr_wb", 12'(s_fc), 12'h1);
        clr_inputs();

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) < 3);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            UsesRs1D   = 1'($urandom);
            UsesRs2D   = 1'($urandom);
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdWB       = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom);
            RegWriteWB = 1'($urandom);
            ResultSrcE = 3'($urandom_range(0, 2));
            PCSrcE     = ($urandom_range(0, 99) < 20);
            McE        = ($urandom_range(0, 99) < 35);
            CSRReadE   = 1'($urandom);
            CSRWriteM  = 1'($urandom);
            CSRWriteWB = 1'($urandom);
            CSRAddrE   = csr_pool[$urandom_range(0, 2)];
            CSRAddrM   = csr_pool[$urandom_range(0, 2)];
            CSRAddrWB  = csr_pool[$urandom_range(0, 2)];
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 Parameters SHALL be, one per line:
- MC_LATENCY, default 4: number of cycles a multicycle instruction occupies E; legal range 1..15.
- RS_W, default 3: width of ResultSrcE.
- LOAD_SRC, default 3'b001: ResultSrcE encoding for a load.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  D-stage source registers.
- UsesRs1D, UsesRs2D  in  1  the D instruction really reads Rs1D / Rs2D.
- Rs1E, Rs2E, RdE  in  5  E-stage sources and destination.
- RdM, RdWB  in  5  M and WB destination registers.
- RegWriteM, RegWriteWB  in  1  M / WB writes the register file.
- ResultSrcE  in  RS_W  E-stage result select.
- PCSrcE  in  1  branch/jump taken in E.
- McE  in  1  the E instruction is multicycle (level; stays high while held in E).
- CSRReadE  in  1  the E instruction reads a CSR.
- CSRAddrE, CSRAddrM, CSRAddrWB  in  12  CSR addresses per stage.
- CSRWriteM, CSRWriteWB  in  1  M / WB writes a CSR.
- StallF, StallD, StallE  out  1  hold the F / D / E pipeline registers.
- FlushD, FlushE, FlushM  out  1  bubble the D / E / M pipeline registers.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 WB, 10 M.
- ForwardCSRE  out  2  CSR read select: 00 CSR file, 01 WB, 10 M.
- McBusy  out  1  a multicycle stall is active this cycle.
- McDoneE  out  1  final E cycle of a multicycle instruction.

Function
REQ-003 ForwardAE SHALL be 10 if Rs1E==RdM & RegWriteM & Rs1E!=0, else 01 if Rs1E==RdWB & RegWriteWB & Rs1E!=0, else 00; ForwardBE SHALL be the same using Rs2E.
REQ-004 ForwardCSRE SHALL be 10 if CSRReadE & CSRWriteM & CSRAddrM==CSRAddrE, else 01 if CSRReadE & CSRWriteWB & CSRAddrWB==CSRAddrE, else 00; M has priority.
REQ-005 lw = (ResultSrcE==LOAD_SRC) & RdE!=0 & ((UsesRs1D & Rs1D==RdE) | (UsesRs2D & Rs2D==RdE)) & !PCSrcE; a taken branch SHALL suppress load-use stalls.
REQ-006 The FSM SHALL have states IDLE and BUSY and a counter cnt of 4 bits; IDLE implies cnt=0.
REQ-007 In IDLE with McE=1 and MC_LATENCY>1: mcstall=1 this cycle; next state BUSY with cnt=1.
REQ-008 In IDLE with McE=1 and MC_LATENCY==1: McDoneE=1 and no stall; the FSM stays in IDLE.
REQ-009 In BUSY, if cnt+1==MC_LATENCY: McDoneE=1, mcstall=0, next state IDLE with cnt=0; otherwise mcstall=1 and cnt increments.
REQ-010 A multicycle instruction SHALL therefore occupy E for exactly MC_LATENCY cycles; an immediately following multicycle instruction SHALL start fresh from IDLE.
REQ-011 McBusy SHALL equal mcstall.
REQ-012 PCSrcE and McE SHALL be ignored in BUSY.
REQ-013 When mcstall=1: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0, and lw SHALL be ignored.
REQ-014 Otherwise: StallF=StallD=lw, StallE=0, FlushD=PCSrcE, FlushE=PCSrcE|lw, FlushM=0.
REQ-015 FlushE and StallE SHALL never both be 1.

Reset
REQ-016 When reset=1 at a clock edge: state SHALL become IDLE and cnt SHALL become 0.
REQ-017 While reset=1: StallF/D/E=0, FlushD/E/M=1, ForwardAE/BE/CSRE=00, McBusy=0, McDoneE=0.
REQ-018 Reset asserted mid-BUSY SHALL abort the count; after deassertion, a McE still high SHALL start a new full MC_LATENCY sequence.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Rs1E=5, RdM=5, RegWriteM=1, RdWB=5, RegWriteWB=1 -> ForwardAE=10; same with Rs1E=0 -> 00.
- Load in E with RdE=7, D has Rs2D=7, UsesRs2D=1 -> StallF=StallD=FlushE=1 for 1 cycle; same with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
- MC_LATENCY=4, McE held high -> McBusy/StallE/FlushM=1 for 3 cycles, McDoneE=1 in cycle 4, FlushE=0 throughout.
- Two back-to-back MC instructions -> stall pattern 1,1,1,0,1,1,1,0; load-use during BUSY produces no FlushE.
- reset in cycle 2 of BUSY -> outputs take reset values; after deassertion, a full 3-cycle stall then McDoneE.
- CSRReadE=1, CSRAddrE=0x300, CSRWriteM=1, CSRAddrM=0x300 -> ForwardCSRE=10; M address 0x305 with WB address 0x300 writing -> 01.
